sim_end_monitor: RTL

Parametrised simulation-termination monitor for the wujian100 bench. It generalises the single free-running CPU clock counter and fixed max-time check into one block with:
- a saturating cycle counter;
- a configurable global cycle budget;
- NUM_CH per-channel heartbeat stall watchdogs;
- a prioritised pass/fail/timeout/stall verdict FSM.

It sits beside the DUT in the bench top. Its verdict outputs drive report writing and $finish.

---
 rtl/sim_end_monitor_pkg.sv | 28 ++
 rtl/sim_end_monitor_stall_ch.sv | 35 +++
 rtl/sim_end_monitor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sim_end_monitor_pkg.sv
// Shared types for the simulation-end monitor: FSM state encoding, verdict
// result codes and a lowest-index priority encoder for the stall mask.
package sim_end_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam logic [1:0] RES_NONE    = 2'b00;
   localparam logic [1:0] RES_PASS    = 2'b01;
   localparam logic [1:0] RES_FAIL    = 2'b10;
   localparam logic [1:0] RES_TIMEOUT = 2'b11;

   // Scanning from the top down leaves the lowest set index as the final winner.
   function automatic logic [3:0] lowest_set(input logic [15:0] mask);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sim_end_monitor_stall_ch.sv
// One heartbeat watchdog channel: counts consecutive heartbeat-free cycles
// while running and flags the cycle in which the tolerated count is reached.
module sim_end_monitor_stall_ch
   import sim_end_monitor_pkg::*;
#(
   parameter int          STALL_W      = 16,
   parameter int unsigned STALL_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic en,
   input  logic hb,
   output logic stalled
);

   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
   localparam logic [STALL_W-1:0] CNT_MAX    = '1;
   localparam logic [STALL_W-1:0] CNT_ONE    = {{(STALL_W-1){1'b0}}, 1'b1};

   logic [STALL_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || hb || !en) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign stalled = run && en && !hb && (cnt == STALL_LAST);

endmodule

// File: rtl/sim_end_monitor.sv
// Simulation-end monitor: saturating run-cycle counter, global cycle budget,
// per-channel heartbeat watchdogs and a sticky prioritised verdict FSM.
module sim_end_monitor
   import sim_end_monitor_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter int          NUM_CH       = 4,
   parameter int          STALL_W      = 16,
   parameter int unsigned MAX_CYCLES   = 30000000,
   parameter int unsigned STALL_CYCLES = 1000
) (
   input  logic              i_ext_pad_clkmux_ehs_clk,
   input  logic              PI_SOC_RST_B,
   input  logic              start_i,
   input  logic              pass_i,
   input  logic              fail_i,
   input  logic [NUM_CH-1:0] ch_en_i,
   input  logic [NUM_CH-1:0] hb_i,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic [2:0]        state_o,
   output logic              done_o,
   output logic [1:0]        result_o,
   output logic              stall_o,
   output logic [3:0]        stall_ch_o,
   output logic [NUM_CH-1:0] stall_mask_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cycle_cnt_q;
   logic [NUM_CH-1:0] stalled;
   logic [NUM_CH-1:0] stall_mask_q;
   logic [3:0]        stall_ch_q;
   logic              stall_q;
   logic              capture_stall;
   logic              run;
   logic              any_stall;
   logic              timeout_hit;

   assign run       = (state_q == ST_RUN);
   assign any_stall = |stalled;
   // Widened compare so a budget beyond the counter range simply never fires.
   assign timeout_hit = (64'(cycle_cnt_q) == (64'(MAX_CYCLES) - 64'd1));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sim_end_monitor_stall_ch #(
         .STALL_W      (STALL_W),
         .STALL_CYCLES (STALL_CYCLES)
      ) u_ch (
         .clk     (i_ext_pad_clkmux_ehs_clk),
         .rst     (PI_SOC_RST_B),
         .run     (run),
         .en      (ch_en_i[g]),
         .hb      (hb_i[g]),
         .stalled (stalled[g])
      );
   end

   always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
      if (PI_SOC_RST_B) begin
         state_q      <= ST_IDLE;
         cycle_cnt_q  <= '0;
         stall_q      <= 1'b0;
         stall_ch_q   <= '0;
         stall_mask_q <= '0;
      end else begin
         state_q <= state_d;
         if (run) begin
            if (cycle_cnt_q != CNT_MAX) cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
         end else if (state_q == ST_IDLE) begin
            cycle_cnt_q <= '0;
         end
         if (capture_stall) begin
            stall_q      <= 1'b1;
            stall_ch_q   <= lowest_set(16'(stalled));
            stall_mask_q <= stalled;
         end
      end
   end

   // Verdict priority: explicit fail, then stall, then pass, then budget.
   always_comb begin
      state_d       = state_q;
      capture_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (fail_i) begin
               state_d = ST_FAIL;
            end else if (any_stall) begin
               state_d       = ST_FAIL;
               capture_stall = 1'b1;
            end else if (pass_i) begin
               state_d = ST_PASS;
            end else if (timeout_hit) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      result_o = RES_NONE;
      done_o   = 1'b0;
      case (state_q)
         ST_PASS:    begin result_o = RES_PASS;    done_o = 1'b1; end
         ST_FAIL:    begin result_o = RES_FAIL;    done_o = 1'b1; end
         ST_TIMEOUT: begin result_o = RES_TIMEOUT; done_o = 1'b1; end
         default:    begin result_o = RES_NONE;    done_o = 1'b0; end
      endcase
   end

   assign cycle_cnt_o  = cycle_cnt_q;
   assign state_o      = state_q;
   assign stall_o      = stall_q;
   assign stall_ch_o   = stall_ch_q;
   assign stall_mask_o = stall_mask_q;

endmodule
